// File: rtl/stream_len_meter_pkg.sv
// Shared types and constants for the stream length meter.
package stream_len_meter_pkg;

  localparam int unsigned SIZE      = 12;
  localparam int unsigned LEN_W     = SIZE;
  localparam int unsigned DEF_DEPTH = 4;

  // Lengths leave the block as (beats - 1); a 1-beat packet reports 0.
  localparam bit LEN_ENC_MINUS1 = 1'b1;

  typedef struct packed {
    logic             sat;
    logic [LEN_W-1:0] len;
  } len_entry_t;

endpackage

// File: rtl/stream_len_meter_len_fifo.sv
// Synchronous length FIFO with a registered head entry (no fall-through).
module stream_len_meter_len_fifo
  import stream_len_meter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_push,
  input  logic       i_pop,
  input  len_entry_t i_data,
  output len_entry_t o_data,
  output logic       o_valid,
  output logic       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  len_entry_t       r_mem [DEPTH];
  len_entry_t       r_head;
  len_entry_t       w_head_nxt;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_wr_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_valid;
  logic             r_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & r_valid & ~i_clr;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ~i_clr & (~r_full | w_do_pop);

  always_comb begin
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    if (i_clr) begin
      w_wr_nxt    = '0;
      w_rd_nxt    = '0;
      w_count_nxt = '0;
      w_head_nxt  = '0;
    end else begin
      if (w_do_push) w_wr_nxt = r_wr_ptr + AW'(1);
      if (w_do_pop)  w_rd_nxt = r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
      // Head follows the read pointer; a push landing on the new head slot is forwarded.
      if (w_do_pop) begin
        w_head_nxt = (w_do_push && (r_wr_ptr == w_rd_nxt)) ? i_data : r_mem[w_rd_nxt];
      end else if (w_do_push && !r_valid) begin
        w_head_nxt = i_data;
      end
      if (w_count_nxt == '0) w_head_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_full   <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_full  = r_full;

endmodule

// File: rtl/stream_len_meter.sv
// Passive valid/ready/last monitor: measures each packet's beat count and queues it
// as (beats-1) with a saturation flag.
module stream_len_meter
  import stream_len_meter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_ready,
  input  logic             in_last,
  output logic [LEN_W-1:0] len_data,
  output logic             len_sat,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             busy,
  output logic             overflow
);

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_sat;
  logic             w_sat_nxt;
  logic             r_busy;
  logic             r_overflow;
  logic             w_beat;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_fifo_valid;
  len_entry_t       w_push_ent;
  len_entry_t       w_head;

  assign w_beat = en & in_valid & in_ready & ~clr;
  assign w_push = w_beat & in_last;
  assign w_pop  = w_fifo_valid & len_ready & ~clr;

  always_comb begin
    w_push_ent.sat = r_sat;
    w_push_ent.len = LEN_ENC_MINUS1 ? r_cnt : r_cnt + LEN_W'(1);
  end

  // Beat counter: saturates at all-ones and restarts on the last beat.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (clr) begin
      w_cnt_nxt = '0;
      w_sat_nxt = 1'b0;
    end else if (w_beat) begin
      if (in_last) begin
        w_cnt_nxt = '0;
        w_sat_nxt = 1'b0;
      end else if (&r_cnt) begin
        w_sat_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sat  <= w_sat_nxt;
      r_busy <= (w_cnt_nxt != '0) | w_sat_nxt;
      if (clr)                           r_overflow <= 1'b0;
      else if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  stream_len_meter_len_fifo #(
    .DEPTH (DEPTH)
  ) u_len_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_ent),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_full  (w_full)
  );

  assign len_data  = w_head.len;
  assign len_sat   = w_head.sat;
  assign len_valid = w_fifo_valid;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule
